// File: rtl/axi4s_frame_encoder.sv
// -----------------------------------------------------------------------------
// axi4s_frame_encoder
//
// Transmit-side framing engine. Turns a tlast-delimited AXI4-Stream packet into
// an escaped byte stream:  START [HDR] payload [CSUM] STOP
//   - HDR  : zero-extended target_tdest sampled with the first beat (HEADER_EN)
//   - CSUM : two's-complement of (HDR + payload) mod 256 (CHECKSUM_EN)
//   - Any reserved byte (ESCAPE/START/STOP) inside HDR, payload or CSUM is sent
//     as ESCAPE_BYTE followed by the byte itself. Markers are never escaped.
//
// Ports
//   aclk, aresetn                 clock, asynchronous active-low reset
//   target_tvalid/tready/tdata/tlast/tdest   packet input (AXI4-Stream)
//   initiator_tvalid/tready/tdata            encoded byte output (registered)
//   busy                          high from START load until STOP accepted
// -----------------------------------------------------------------------------
module axi4s_frame_encoder #(
  parameter logic [7:0]  ESCAPE_BYTE = 8'h7F,
  parameter logic [7:0]  START_BYTE  = 8'h7D,
  parameter logic [7:0]  STOP_BYTE   = 8'h7E,
  parameter bit          HEADER_EN   = 1'b1,
  parameter int unsigned DEST_WIDTH  = 4,
  parameter bit          CHECKSUM_EN = 1'b1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  target_tvalid,
  output logic                  target_tready,
  input  logic [7:0]            target_tdata,
  input  logic                  target_tlast,
  input  logic [DEST_WIDTH-1:0] target_tdest,
  output logic                  initiator_tvalid,
  input  logic                  initiator_tready,
  output logic [7:0]            initiator_tdata,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_DATA,
    S_CSUM,
    S_STOP
  } state_t;

  state_t                state, state_nx;
  logic                  out_valid, out_valid_nx;
  logic [7:0]            out_data, out_data_nx;
  logic                  pending, pending_nx;
  logic [7:0]            pend_data, pend_data_nx;
  logic [7:0]            csum, csum_nx;
  logic [DEST_WIDTH-1:0] dest_q, dest_nx;
  logic                  busy_q, busy_nx;
  // Marks that the byte in the output register is the STOP marker; a payload
  // byte equal to STOP_BYTE must not end busy, so value compare is not enough.
  logic                  stop_out, stop_out_nx;

  logic                  slot_free;
  logic [7:0]            hdr_byte;
  logic [7:0]            csum_neg;
  logic                  raw_en;
  logic [7:0]            raw_byte;

  function automatic logic is_reserved(input logic [7:0] b);
    return (b == ESCAPE_BYTE) || (b == START_BYTE) || (b == STOP_BYTE);
  endfunction

  assign slot_free        = !out_valid || initiator_tready;
  assign target_tready    = (state == S_DATA) && slot_free && !pending;
  assign initiator_tvalid = out_valid;
  assign initiator_tdata  = out_data;
  assign busy             = busy_q;
  assign csum_neg         = 8'd0 - csum;

  always_comb begin
    hdr_byte = '0;
    hdr_byte[DEST_WIDTH-1:0] = dest_q;
  end

  always_comb begin
    state_nx     = state;
    out_valid_nx = out_valid && !initiator_tready;
    out_data_nx  = out_data;
    pending_nx   = pending;
    pend_data_nx = pend_data;
    csum_nx      = csum;
    dest_nx      = dest_q;
    stop_out_nx  = stop_out && !initiator_tready;
    busy_nx      = busy_q && !(out_valid && initiator_tready && stop_out);
    raw_en       = 1'b0;
    raw_byte     = '0;

    if (slot_free) begin
      if (pending) begin
        // second half of an escape pair goes out before anything else
        out_valid_nx = 1'b1;
        out_data_nx  = pend_data;
        pending_nx   = 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (target_tvalid) begin
              out_valid_nx = 1'b1;
              out_data_nx  = START_BYTE;
              dest_nx      = target_tdest;
              csum_nx      = '0;
              busy_nx      = 1'b1;
              state_nx     = HEADER_EN ? S_HEADER : S_DATA;
            end
          end
          S_HEADER: begin
            raw_en   = 1'b1;
            raw_byte = hdr_byte;
            csum_nx  = csum + hdr_byte;
            state_nx = S_DATA;
          end
          S_DATA: begin
            if (target_tvalid) begin
              raw_en   = 1'b1;
              raw_byte = target_tdata;
              csum_nx  = csum + target_tdata;
              if (target_tlast) state_nx = CHECKSUM_EN ? S_CSUM : S_STOP;
            end
          end
          S_CSUM: begin
            raw_en   = 1'b1;
            raw_byte = csum_neg;
            state_nx = S_STOP;
          end
          S_STOP: begin
            out_valid_nx = 1'b1;
            out_data_nx  = STOP_BYTE;
            stop_out_nx  = 1'b1;
            state_nx     = S_IDLE;
          end
          default: state_nx = S_IDLE;
        endcase

        if (raw_en) begin
          out_valid_nx = 1'b1;
          if (is_reserved(raw_byte)) begin
            out_data_nx  = ESCAPE_BYTE;
            pending_nx   = 1'b1;
            pend_data_nx = raw_byte;
          end else begin
            out_data_nx  = raw_byte;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      pending   <= 1'b0;
      pend_data <= '0;
      csum      <= '0;
      dest_q    <= '0;
      busy_q    <= 1'b0;
      stop_out  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= out_valid_nx;
      out_data  <= out_data_nx;
      pending   <= pending_nx;
      pend_data <= pend_data_nx;
      csum      <= csum_nx;
      dest_q    <= dest_nx;
      busy_q    <= busy_nx;
      stop_out  <= stop_out_nx;
    end
  end

endmodule

// File: tb/tb_axi4s_frame_encoder.sv
// -----------------------------------------------------------------------------
// Testbench for axi4s_frame_encoder: a full-featured instance (header+checksum)
// and a minimal instance (no header, no checksum).
// -----------------------------------------------------------------------------
module tb_axi4s_frame_encoder;

  logic       aclk;
  logic       aresetn;
  logic       t_valid, t_ready, t_last;
  logic [7:0] t_data;
  logic [3:0] t_dest;
  logic       i_valid, i_ready;
  logic [7:0] i_data;
  logic       busy;

  logic       m_t_valid, m_t_ready, m_t_last;
  logic [7:0] m_t_data;
  logic [3:0] m_t_dest;
  logic       m_i_valid, m_i_ready;
  logic [7:0] m_i_data;
  logic       m_busy;

  int unsigned total, passed;
  int unsigned cyc;
  int unsigned busy_cnt;
  int unsigned start_cyc;
  logic [7:0]  out_q[$], m_out_q[$], exp_q[$], pl[$];
  int unsigned out_cyc[$];
  bit          bp_en;
  bit          hold_prev;
  logic [7:0]  prev_data;
  bit          prev_res_hs;

  typedef struct {
    logic [3:0]  dest;
    int unsigned n_pl;
    logic [31:0] pl;   // payload bytes, first byte in the MSBs
    int unsigned n_ex;
    logic [63:0] ex;   // expected encoded bytes, first byte in the MSBs
  } vec_t;
  vec_t vecs [5];

  axi4s_frame_encoder #(
    .HEADER_EN   (1'b1),
    .DEST_WIDTH  (4),
    .CHECKSUM_EN (1'b1)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (t_valid),
    .target_tready    (t_ready),
    .target_tdata     (t_data),
    .target_tlast     (t_last),
    .target_tdest     (t_dest),
    .initiator_tvalid (i_valid),
    .initiator_tready (i_ready),
    .initiator_tdata  (i_data),
    .busy             (busy)
  );

  axi4s_frame_encoder #(
    .HEADER_EN   (1'b0),
    .DEST_WIDTH  (4),
    .CHECKSUM_EN (1'b0)
  ) dut_min (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .target_tvalid    (m_t_valid),
    .target_tready    (m_t_ready),
    .target_tdata     (m_t_data),
    .target_tlast     (m_t_last),
    .target_tdest     (m_t_dest),
    .initiator_tvalid (m_i_valid),
    .initiator_tready (m_i_ready),
    .initiator_tdata  (m_i_data),
    .busy             (m_busy)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1);
  end

  // downstream ready: random when backpressure is enabled
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      i_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic bit is_res(input logic [7:0] b);
    return (b == 8'h7D) || (b == 8'h7E) || (b == 8'h7F);
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // output monitor
  initial forever begin
    @(negedge aclk);
    if (busy) busy_cnt++;
    if (aresetn) begin
      if (hold_prev) begin
        check_eq("hold_tvalid", 32'(i_valid), 32'd1);
        check_eq("hold_tdata", 32'(i_data), 32'(prev_data));
      end
      if (prev_res_hs) check_eq("tready_after_reserved", 32'(t_ready), 32'd0);
      if (i_valid && i_ready) begin
        out_q.push_back(i_data);
        out_cyc.push_back(cyc);
      end
      if (m_i_valid && m_i_ready) m_out_q.push_back(m_i_data);
      hold_prev   = i_valid && !i_ready;
      prev_data   = i_data;
      prev_res_hs = t_valid && t_ready && is_res(t_data);
    end else begin
      hold_prev   = 1'b0;
      prev_res_hs = 1'b0;
    end
  end

  // Reference encoder: appends the expected frame for payload pl to exp_q.
  task automatic model_frame(input bit hdr, input bit cs, input logic [3:0] dest);
    int unsigned sum;
    sum = 0;
    exp_q.push_back(8'h7D);
    if (hdr) begin
      if (is_res(8'(dest))) exp_q.push_back(8'h7F);
      exp_q.push_back(8'(dest));
      sum += 32'(dest);
    end
    foreach (pl[j]) begin
      if (is_res(pl[j])) exp_q.push_back(8'h7F);
      exp_q.push_back(pl[j]);
      sum += 32'(pl[j]);
    end
    if (cs) begin
      logic [7:0] c;
      c = 8'((256 - (sum % 256)) % 256);
      if (is_res(c)) exp_q.push_back(8'h7F);
      exp_q.push_back(c);
    end
    exp_q.push_back(8'h7E);
  endtask

  task automatic wait_accept(input bit which);
    int unsigned k;
    bit acc;
    k = 0;
    acc = 1'b0;
    while (!acc && k < 300) begin
      @(negedge aclk);
      acc = which ? m_t_ready : t_ready;
      @(posedge aclk);
      #1;
      k++;
    end
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drive_frame(input bit which, input logic [3:0] dest);
    logic [3:0] d;
    for (int i = 0; i < pl.size(); i++) begin
      d = (i == 0) ? dest : 4'($urandom);
      if (which) begin
        m_t_valid = 1'b1; m_t_data = pl[i]; m_t_last = (i == pl.size() - 1); m_t_dest = d;
      end else begin
        t_valid = 1'b1; t_data = pl[i]; t_last = (i == pl.size() - 1); t_dest = d;
      end
      wait_accept(which);
    end
    if (which) begin m_t_valid = 1'b0; m_t_last = 1'b0; end
    else begin t_valid = 1'b0; t_last = 1'b0; end
  endtask

  task automatic wait_out(input bit which, input int unsigned n);
    int unsigned k;
    k = 0;
    while ((which ? m_out_q.size() : out_q.size()) < n && k < 3000) begin
      @(negedge aclk);
      k++;
    end
    if ((which ? m_out_q.size() : out_q.size()) < n)
      check_eq("out_timeout", which ? m_out_q.size() : out_q.size(), n);
    repeat (6) @(negedge aclk);
    @(posedge aclk);
    #1;
  endtask

  task automatic compare_out(input bit which, input string name);
    logic [7:0] got[$];
    int unsigned n;
    bit ok;
    got = which ? m_out_q : out_q;
    check_eq({name, "_len"}, got.size(), exp_q.size());
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      ok = (got[i] === exp_q[i]);
      check_eq($sformatf("%s_byte%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
      if (!ok) break;
    end
  endtask

  task automatic run_vec(input vec_t vt, input bit timing, input string name);
    out_q.delete(); out_cyc.delete(); exp_q.delete(); pl.delete();
    for (int i = 0; i < vt.n_pl; i++) pl.push_back(vt.pl[31-8*i -: 8]);
    for (int i = 0; i < vt.n_ex; i++) exp_q.push_back(vt.ex[63-8*i -: 8]);
    busy_cnt  = 0;
    start_cyc = cyc;
    drive_frame(1'b0, vt.dest);
    wait_out(1'b0, vt.n_ex);
    compare_out(1'b0, name);
    if (timing && out_cyc.size() > 0) begin
      check_eq({name, "_latency"}, out_cyc[0] - start_cyc, 32'd1);
      check_eq({name, "_span"}, out_cyc[out_cyc.size()-1] - out_cyc[0], vt.n_ex - 1);
      check_eq({name, "_busy_cycles"}, busy_cnt, vt.n_ex);
    end
  endtask

  function automatic logic [7:0] rand_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if ($urandom_range(0, 2) == 0) begin
      case ($urandom_range(0, 2))
        0:       b = 8'h7D;
        1:       b = 8'h7E;
        default: b = 8'h7F;
      endcase
    end
    return b;
  endfunction

  initial begin
    int unsigned k, n;
    logic [3:0]  d;

    vecs[0] = '{4'h3, 2, 32'h0102_0000, 6, 64'h7D03_0102_FA7E_0000};
    vecs[1] = '{4'h3, 1, 32'h7E00_0000, 7, 64'h7D03_7F7E_7F7F_7E00};
    vecs[2] = '{4'h0, 2, 32'h7D00_0000, 7, 64'h7D00_7F7D_0083_7E00};
    vecs[3] = '{4'hF, 1, 32'h7F00_0000, 6, 64'h7D0F_7F7F_727E_0000};
    vecs[4] = '{4'h3, 1, 32'h8000_0000, 6, 64'h7D03_807F_7D7E_0000};

    aresetn = 1'b0;
    t_valid = 1'b0; t_data = '0; t_last = 1'b0; t_dest = '0;
    m_t_valid = 1'b0; m_t_data = '0; m_t_last = 1'b0; m_t_dest = '0;
    m_i_ready = 1'b1;
    bp_en = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check_eq("rst_tvalid", 32'(i_valid), 32'd0);
    check_eq("rst_tdata", 32'(i_data), 32'h00);
    check_eq("rst_tready", 32'(t_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_min_tvalid", 32'(m_i_valid), 32'd0);
    check_eq("rst_min_busy", 32'(m_busy), 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // table of single frames, downstream always ready
    for (int v = 0; v < 5; v++) run_vec(vecs[v], 1'b1, $sformatf("vec%0d", v));

    // minimal configuration
    m_out_q.delete(); exp_q.delete();
    pl = '{8'hAA};
    drive_frame(1'b1, 4'h0);
    wait_out(1'b1, 3);
    exp_q = '{8'h7D, 8'hAA, 8'h7E};
    compare_out(1'b1, "minimal");

    // backpressure on basic frame
    bp_en = 1'b1;
    run_vec(vecs[0], 1'b0, "backpressure");
    bp_en = 1'b0;
    repeat (2) begin @(posedge aclk); #1; end

    // back-to-back frames, target_tvalid continuous
    out_q.delete(); out_cyc.delete(); busy_cnt = 0;
    exp_q = '{8'h7D, 8'h01, 8'h10, 8'hEF, 8'h7E, 8'h7D, 8'h02, 8'h20, 8'hDE, 8'h7E};
    pl = '{8'h10};
    drive_frame(1'b0, 4'h1);
    pl = '{8'h20};
    drive_frame(1'b0, 4'h2);
    wait_out(1'b0, 10);
    compare_out(1'b0, "b2b");
    if (out_cyc.size() > 0) check_eq("b2b_span", out_cyc[out_cyc.size()-1] - out_cyc[0], 32'd9);
    check_eq("b2b_busy_cycles", busy_cnt, 32'd10);

    // reset in the middle of a frame, right after the 01 byte went out
    out_q.delete();
    t_valid = 1'b1; t_data = 8'h01; t_last = 1'b0; t_dest = 4'h3;
    wait_accept(1'b0);
    t_data = 8'h02; t_last = 1'b1; t_dest = 4'($urandom);
    wait_accept(1'b0);
    t_valid = 1'b0; t_last = 1'b0;
    k = 0;
    while (out_q.size() < 3 && k < 100) begin @(negedge aclk); k++; end
    check_eq("midrst_bytes_before", out_q.size(), 32'd3);
    aresetn = 1'b0;
    #1;
    check_eq("midrst_tvalid", 32'(i_valid), 32'd0);
    check_eq("midrst_tdata", 32'(i_data), 32'h00);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_tready", 32'(t_ready), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    check_eq("midrst_no_stop", out_q.size(), 32'd3);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    run_vec(vecs[0], 1'b1, "after_reset");

    // randomized frames against the reference model
    out_q.delete(); exp_q.delete();
    for (int f = 0; f < 30; f++) begin
      bp_en = (f >= 10);
      n = $urandom_range(1, 6);
      d = 4'($urandom);
      pl.delete();
      for (int j = 0; j < n; j++) pl.push_back(rand_byte());
      model_frame(1'b1, 1'b1, d);
      drive_frame(1'b0, d);
      repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    end
    wait_out(1'b0, exp_q.size());
    compare_out(1'b0, "rand");
    bp_en = 1'b0;

    m_out_q.delete(); exp_q.delete();
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 5);
      pl.delete();
      for (int j = 0; j < n; j++) pl.push_back(rand_byte());
      model_frame(1'b0, 1'b0, 4'h0);
      drive_frame(1'b1, 4'($urandom));
    end
    wait_out(1'b1, exp_q.size());
    compare_out(1'b1, "rand_min");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi4s_frame_encoder.md
Name: axi4s_frame_encoder

Overview:
Parametrised transmit-side framing engine. It merges escaping and framing into one pipelined block and adds two features: an optional destination header byte from target_tdest and an optional 8-bit two's-complement checksum trailer.
It converts an AXI4-Stream packet (tlast-delimited) into an escaped byte stream START [HDR] payload [CSUM] STOP.
It sits between packet sources and the byte-level TX interface (UART or similar) and replaces the separate escape/frame pair on the TX path.

Parameters:
ESCAPE_BYTE, 8'h7F, escape marker prefixed to any reserved byte
START_BYTE, 8'h7D, frame start marker
STOP_BYTE, 8'h7E, frame stop marker
HEADER_EN, 1, 1 = emit header byte after START; 0 = no header
DEST_WIDTH, 4, width of target_tdest (1..8); header = zero-extended tdest
CHECKSUM_EN, 1, 1 = emit checksum byte before STOP

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
target_tvalid  in  1  packet byte valid
target_tready  out  1  packet byte accepted
target_tdata  in  8  packet byte
target_tlast  in  1  last byte of packet
target_tdest  in  DEST_WIDTH  destination; sampled on first beat only
initiator_tvalid  out  1  encoded byte valid
initiator_tready  in  1  downstream ready
initiator_tdata  out  8  encoded byte
busy  out  1  high from START load until STOP accepted

Behaviour:
- Single clock aclk. Reset is asynchronous and active-low on aresetn. All state is cleared asynchronously.
- Reset values: initiator_tvalid=0, initiator_tdata=8'h00, target_tready=0, busy=0, FSM=IDLE, escape-pending=0, checksum=0.
- Output register: initiator_tvalid/tdata are registered.
  - slot_free = !initiator_tvalid || initiator_tready.
  - The register loads only when slot_free.
  - tdata is held stable while tvalid && !tready.
- Reserved byte = ESCAPE_BYTE, START_BYTE or STOP_BYTE. A reserved byte in header, payload or checksum is sent as ESCAPE_BYTE, then the byte unchanged.
  - The second byte is held in a pending register and emitted at the next slot_free. Nothing else loads while pending=1.
  - START and STOP markers are never escaped.
- Checksum: 8-bit register, cleared when START loads. It adds the header byte (if HEADER_EN) and every payload byte, mod 256, before escaping. The emitted value is (-sum) mod 256, so the sum of header+payload+csum = 0.
- FSM:
  - IDLE: on target_tvalid && slot_free, load START, latch tdest (data not consumed), busy=1. Next state HEADER if HEADER_EN, else DATA.
  - HEADER: on slot_free, load header (or ESCAPE+pending). Go to DATA.
  - DATA: target_tready = slot_free && !pending (combinational).
    - On handshake, load the byte (or ESCAPE+pending) and update the checksum.
    - On a handshake with tlast=1, go to CSUM if CHECKSUM_EN, else STOP.
    - Pending flush precedes the next state's load.
  - CSUM: on slot_free && !pending, load the checksum (or ESCAPE+pending). Go to STOP.
  - STOP: on slot_free && !pending, load STOP. Go to IDLE.
  - busy clears when the STOP byte handshakes on the initiator side.
- target_tready=0 in every state except DATA. tdest on non-first beats is ignored.
- Throughput: one encoded byte per cycle with initiator_tready held high. Each reserved byte costs one extra cycle.
- Latency: START appears on initiator_tvalid 1 cycle after target_tvalid rises in IDLE.
- Back-to-back frames: IDLE may load START in the same cycle the STOP handshake completes. No idle gap is required.
- Empty packets are impossible: a tlast-only beat yields a 1-byte payload.
- Reset mid-frame: the partial frame is dropped with no STOP emitted. The encoder restarts cleanly in IDLE.

Test Plan:
1. Basic frame: HEADER_EN=1, CHECKSUM_EN=1, tdest=3, payload 01 02 (tlast on 02), tready=1 -> output 7D 03 01 02 FA 7E on consecutive cycles; busy high for 6 cycles.
2. Escaping: tdest=3, payload 7E (tlast) -> 7D 03 7F 7E 7F 7F 7E. Checksum 7F is escaped, and target_tready is low in the cycle after 7E is accepted.
3. Minimal: HEADER_EN=0, CHECKSUM_EN=0, payload AA (tlast) -> 7D AA 7E.
4. Backpressure: case 1 with initiator_tready toggled randomly -> identical byte sequence; tdata stable while tvalid && !tready; no byte lost or duplicated.
5. Back-to-back: two frames (tdest 1 then 2, payloads 10 and 20) with target_tvalid continuous -> 7D 01 10 EF 7E 7D 02 20 DE 7E with no gap. Second header uses tdest of the second frame.
6. Reset mid-frame: assert aresetn=0 after the 01 byte of case 1 -> all outputs reset immediately. After release, a new frame encodes exactly as in case 1.
